bus_mem_responder: RTL and testbench
====================================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0100, meaning the first bus address decoded by this block.
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning the number of storage words (power of two, 4..4096).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning the cycles between request acceptance and done assertion (range 0..15).
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the cycles done is held awaiting request drop (used only with MEM_RESP_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port addr, input, `ADDR_SIZE0+1 bits: address driven by the initiator.
REQ-008 SHALL have port data, inout, `DATA_SIZE0+1 bits: shared data bus; write data in, read data out.
REQ-009 SHALL have ports read_q and write_q, input, 1 bit each: read and write requests.
REQ-010 SHALL have ports read_e and write_e, input, 1 bit each: request qualifiers; a request counts only while its qualifier is 1.
REQ-011 SHALL have ports read_dn and write_dn, output, 1 bit each: read and write completion.
REQ-012 SHALL have port bus_busy, inout, 1 bit: driven 1 while servicing, otherwise high-impedance.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RD_DONE, WR_DONE.
REQ-014 Hit SHALL mean BASE_ADDR <= addr < BASE_ADDR+MEM_WORDS, with word index = addr-BASE_ADDR.
- Addresses outside the window SHALL receive no response and SHALL cause no state change.
REQ-015 In IDLE, a hit with read_q&read_e, or with write_q&write_e, SHALL be accepted.
- On acceptance, index, direction and write data SHALL be latched.
- Next state SHALL be WAIT, or the DONE state directly when WAIT_CYCLES=0.
REQ-016 Simultaneous valid read and write SHALL give read priority; the write is not latched.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded at acceptance.
- A read SHALL then go to RD_DONE; a write SHALL then go to WR_DONE.
REQ-018 On entering WR_DONE, the latched data SHALL be written to memory once.
REQ-019 In RD_DONE, the memory word SHALL be driven on data and read_dn=1.
- data SHALL be high-impedance in every other state.
REQ-020 read_dn/write_dn SHALL stay high until the matching q is sampled 0.
- The FSM SHALL then return to IDLE the following cycle with dn=0.
- A new request SHALL be accepted no earlier than the cycle after IDLE is re-entered.
REQ-021 Request drop or qualifier drop during WAIT SHALL abort the transaction: return to IDLE, no write, no dn.
REQ-022 bus_busy SHALL be driven 1 in WAIT, RD_DONE and WR_DONE, and high-impedance in IDLE.
REQ-023 Acceptance-to-dn latency SHALL be WAIT_CYCLES+1 cycles.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, read_dn=0, write_dn=0, data=Z, bus_busy=Z and the wait counter to 0, including mid-transaction.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 A transaction interrupted by reset SHALL perform no write.

Configuration
REQ-027 Macro MEM_RESP_TIMEOUT_EN defined SHALL enable a counter in RD_DONE/WR_DONE.
- If q is still 1 after TIMEOUT cycles with dn high, the block SHALL return to IDLE, dropping dn and releasing data and bus_busy.
- A write already performed SHALL remain.
REQ-028 Macro MEM_RESP_TIMEOUT_EN undefined SHALL hold dn indefinitely until q drops, with no counter logic present.

Verification
REQ-029 Write then read, defaults: write addr=0x105 data=0xDEADBEEF.
- Response: write_dn at cycle +3.
- Read addr=0x105: data=0xDEADBEEF with read_dn at cycle +3.
REQ-030 Miss: read_q with addr=0x0FF, then addr=0x200 -> read_dn stays 0 and bus_busy stays Z for 20 cycles.
REQ-031 Collision: read_q=write_q=1 at addr=0x110, with write data 0x1234 and the word holding 0x5555 -> read_dn returns 0x5555; a later read shows 0x5555.
REQ-032 Abort: write_q dropped in WAIT at addr=0x120 -> no write_dn; the word is unchanged on readback.
REQ-033 Reset: rst=0 asserted in RD_DONE -> read_dn=0 and data=Z in the same cycle, without a clock edge; IDLE after release.
REQ-034 Timeout: MEM_RESP_TIMEOUT_EN, TIMEOUT=16, read_q held high -> read_dn drops after 16 cycles; with the macro undefined, read_dn stays high for 100 cycles.

Source files
------------

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - word-addressed bus memory responder with wait states and done handshake
// Optional build macro MEM_RESP_TIMEOUT_EN releases a done handshake held longer than TIMEOUT cycles.

`ifndef ADDR_SIZE0
`define ADDR_SIZE0 31
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif

module bus_mem_responder #(
  parameter logic [`ADDR_SIZE0:0] BASE_ADDR   = 'h0000_0100,
  parameter int unsigned          MEM_WORDS   = 256,
  parameter int unsigned          WAIT_CYCLES = 2,
  parameter int unsigned          TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`ADDR_SIZE0:0]  addr,
  inout  wire  [`DATA_SIZE0:0]  data,
  input  logic                  read_q,
  input  logic                  write_q,
  input  logic                  read_e,
  input  logic                  write_e,
  output logic                  read_dn,
  output logic                  write_dn,
  inout  wire                   bus_busy
);

  localparam int AW    = `ADDR_SIZE0 + 1;
  localparam int DW    = `DATA_SIZE0 + 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] L_WORDS = AW'(MEM_WORDS);
  localparam logic [3:0]    L_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RD_DONE, WR_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_rd;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_mem [MEM_WORDS];

  logic [AW-1:0]    w_offset;
  logic             w_hit;
  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_accept;
  logic             w_live;
  logic             w_timeout;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [DW-1:0]    w_wr_data;

  assign w_offset = addr - BASE_ADDR;
  assign w_hit    = (addr >= BASE_ADDR) && (w_offset < L_WORDS);
  assign w_rd_req = w_hit && read_q && read_e;
  assign w_wr_req = w_hit && write_q && write_e;
  assign w_accept = (r_state == IDLE) && (w_rd_req || w_wr_req);
  // The accepted request must stay asserted and qualified through WAIT, else it aborts.
  assign w_live   = r_rd ? (read_q && read_e) : (write_q && write_e);

`ifdef MEM_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] L_TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == RD_DONE || r_state == WR_DONE) && (w_next == r_state)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_to_cnt == L_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rd_req) begin
          w_next     = (L_WAIT == 4'd0) ? RD_DONE : WAIT;
          w_cnt_next = L_WAIT;
        end else if (w_wr_req) begin
          w_next     = (L_WAIT == 4'd0) ? WR_DONE : WAIT;
          w_cnt_next = L_WAIT;
        end
      end
      WAIT: begin
        if (!w_live) begin
          w_next     = IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_next     = r_rd ? RD_DONE : WR_DONE;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RD_DONE: begin
        if (!read_q || w_timeout) begin
          w_next = IDLE;
        end
      end
      WR_DONE: begin
        if (!write_q || w_timeout) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_rd    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx <= w_offset[IDX_W-1:0];
        r_rd  <= w_rd_req;
        if (!w_rd_req) begin
          r_wdata <= data;
        end
      end
    end
  end

  // With zero wait states the write commits on the acceptance edge, straight from the bus.
  assign w_wr_en   = rst && (r_state != WR_DONE) && (w_next == WR_DONE);
  assign w_wr_idx  = (r_state == IDLE) ? w_offset[IDX_W-1:0] : r_idx;
  assign w_wr_data = (r_state == IDLE) ? data : r_wdata;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign read_dn  = (r_state == RD_DONE);
  assign write_dn = (r_state == WR_DONE);
  assign data     = (r_state == RD_DONE) ? r_mem[r_idx] : 'z;
  assign bus_busy = (r_state != IDLE) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - randomized self-checking bench for bus_mem_responder against an array model
// Released bus lines are pulled low so a high-impedance data/bus_busy reads as zero.

module tb_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          WORDS = 256;
  localparam int          LAT   = 3;
  localparam int          TO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_q, write_q, read_e, write_e;
  logic        read_dn, write_dn;
  tri0  [31:0] data;
  tri0         bus_busy;
  logic        tb_drv;
  logic [31:0] tb_wdata;

  assign data = tb_drv ? tb_wdata : 'z;

  bus_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .read_q   (read_q),
    .write_q  (write_q),
    .read_e   (read_e),
    .write_e  (write_e),
    .read_dn  (read_dn),
    .write_dn (write_dn),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_mem   [WORDS];
  bit          m_known [WORDS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One bus transaction; lat is the negedge count from request to first dn, -1 if none.
  task automatic run_xact(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int abort_at, output int lat, output logic [31:0] rdata,
                          output bit rdn, output bit wdn, output bit busy1);
    @(negedge clk);
    addr = a; read_q = rd; read_e = rd; write_q = wr; write_e = wr;
    tb_wdata = wd; tb_drv = wr;
    lat = -1; rdata = '0; rdn = 0; wdn = 0; busy1 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      tb_drv = 0;
      if (c == 1) busy1 = bus_busy;
      if (c == abort_at) begin read_q = 0; write_q = 0; end
      if (read_dn || write_dn) begin
        lat = c; rdata = data; rdn = read_dn; wdn = write_dn;
        break;
      end
    end
    read_q = 0; write_q = 0; read_e = 0; write_e = 0;
    if (lat > 0) begin
      @(negedge clk);
      check_eq("dn_release", {30'd0, read_dn, write_dn}, 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input string tag);
    int lat; logic [31:0] rd; bit rdn, wdn, b;
    run_xact(0, 1, a, wd, 0, lat, rd, rdn, wdn, b);
    check_eq({tag, "_wr_lat"}, lat, LAT);
    check_eq({tag, "_wr_dn"}, {31'd0, wdn}, 32'd1);
    m_mem[a - BASE] = wd; m_known[a - BASE] = 1;
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    int lat; logic [31:0] rd; bit rdn, wdn, b;
    run_xact(1, 0, a, 32'h0, 0, lat, rd, rdn, wdn, b);
    check_eq({tag, "_rd_lat"}, lat, LAT);
    check_eq({tag, "_rd_busy"}, {31'd0, b}, 32'd1);
    if (m_known[a - BASE]) check_eq({tag, "_rd_data"}, rd, m_mem[a - BASE]);
  endtask

  task automatic check_miss(input logic [31:0] a, input string tag);
    int hits = 0;
    @(negedge clk);
    addr = a; read_q = 1; read_e = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (read_dn || write_dn || bus_busy) hits++;
    end
    read_q = 0; read_e = 0;
    check_eq(tag, hits, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, cnt; logic [31:0] rd, a, wd; bit rdn, wdn, b; int idx, op;
    rst = 0; addr = '0; read_q = 0; write_q = 0; read_e = 0; write_e = 0;
    tb_drv = 0; tb_wdata = '0;
    for (int i = 0; i < WORDS; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    repeat (2) @(negedge clk);
    check_eq("rst_read_dn", {31'd0, read_dn}, 32'd0);
    check_eq("rst_write_dn", {31'd0, write_dn}, 32'd0);
    check_eq("rst_busy", {31'd0, bus_busy}, 32'd0);
    check_eq("rst_data", data, 32'd0);
    rst = 1;

    do_write(32'h105, 32'hDEAD_BEEF, "basic");
    do_read(32'h105, "basic");

    check_miss(32'h0FF, "miss_below");
    check_miss(32'h200, "miss_above");

    do_write(32'h110, 32'h5555, "coll_pre");
    run_xact(1, 1, 32'h110, 32'h1234, 0, lat, rd, rdn, wdn, b);
    check_eq("coll_lat", lat, LAT);
    check_eq("coll_rdn", {31'd0, rdn}, 32'd1);
    check_eq("coll_data", rd, 32'h5555);
    do_read(32'h110, "coll_post");

    do_write(32'h120, 32'hA5A5_0120, "abort_pre");
    run_xact(0, 1, 32'h120, 32'hFFFF_0000, 1, lat, rd, rdn, wdn, b);
    check_eq("abort_no_dn", lat, -1);
    do_read(32'h120, "abort_post");

    do_write(32'h130, 32'hC0FF_EE01, "rst_pre");
    @(negedge clk);
    addr = 32'h130; read_q = 1; read_e = 1;
    cnt = 0;
    for (int c = 0; c < 12 && !read_dn; c++) begin @(negedge clk); cnt++; end
    check_eq("rst_mid_dn_seen", {31'd0, read_dn}, 32'd1);
    check_eq("rst_mid_data_before", data, 32'hC0FF_EE01);
    #2 rst = 0;
    #1;
    check_eq("rst_mid_read_dn", {31'd0, read_dn}, 32'd0);
    check_eq("rst_mid_data", data, 32'd0);
    check_eq("rst_mid_busy", {31'd0, bus_busy}, 32'd0);
    read_q = 0; read_e = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    check_eq("rst_rel_busy", {31'd0, bus_busy}, 32'd0);
    do_read(32'h130, "rst_keep");

    do_write(32'h131, 32'h0BAD_F00D, "rst_wr_pre");
    @(negedge clk);
    addr = 32'h131; write_q = 1; write_e = 1; tb_wdata = 32'h1111_2222; tb_drv = 1;
    @(negedge clk); tb_drv = 0;
    #2 rst = 0;
    #1 write_q = 0; write_e = 0;
    @(negedge clk); rst = 1;
    do_read(32'h131, "rst_wr_post");

    @(negedge clk);
    addr = 32'h105; read_q = 1; read_e = 1;
    for (int c = 0; c < 12 && !read_dn; c++) @(negedge clk);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!read_dn) break;
      cnt++;
      @(negedge clk);
    end
    read_q = 0; read_e = 0;
`ifdef MEM_RESP_TIMEOUT_EN
    check_eq("timeout_dn_cycles", cnt, TO);
`else
    check_eq("hold_dn_cycles", cnt, 100);
`endif
    repeat (3) @(negedge clk);
    check_eq("timeout_idle_busy", {31'd0, bus_busy}, 32'd0);

    for (int it = 0; it < 60; it++) begin
      idx = $urandom_range(0, WORDS - 1);
      a   = BASE + idx;
      op  = $urandom_range(0, 4);
      wd  = $urandom;
      case (op)
        0: do_write(a, wd, "rnd");
        1: do_read(a, "rnd");
        2: begin
          run_xact(1, 1, a, wd, 0, lat, rd, rdn, wdn, b);
          check_eq("rnd_coll_lat", lat, LAT);
          check_eq("rnd_coll_rdn", {31'd0, rdn}, 32'd1);
          if (m_known[idx]) check_eq("rnd_coll_data", rd, m_mem[idx]);
        end
        3: begin
          run_xact(0, 1, a, wd, $urandom_range(1, 2), lat, rd, rdn, wdn, b);
          check_eq("rnd_abort", lat, -1);
        end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 32'hFF) : (BASE + WORDS + $urandom_range(0, 1000));
          run_xact(1, $urandom_range(0, 1) == 1, a, wd, 0, lat, rd, rdn, wdn, b);
          check_eq("rnd_miss", lat, -1);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
